// File: rtl/mmu_pkg.sv
// Shared definitions for MMU port clients: reader FSM states and the
// memory map region sizes with their derived base addresses.
package mmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int CPURAM_SIZE = 3072;
  localparam int GPUBUF_SIZE = 3072;
  localparam int DSPBUF_SIZE = 1024;
  localparam int DSPRAM_SIZE = 3072;

  localparam int CPURAM_BASE = 0;
  localparam int GPUBUF_BASE = CPURAM_BASE + CPURAM_SIZE;
  localparam int DSPBUF_BASE = GPUBUF_BASE + GPUBUF_SIZE;
  localparam int DSPRAM_BASE = DSPBUF_BASE + DSPBUF_SIZE;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with occupancy count and a synchronous flush.
// Read data is taken straight from the head slot, so a word written at
// one edge is visible on rdata in the following cycle.
module stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmu_stream_reader.sv
// Walks LENGTH consecutive MMU addresses starting at BASE through one MMU
// read port, one word per granted request, and re-presents the fetched
// words as a valid/ready stream through a small FIFO.
module mmu_stream_reader
  import mmu_pkg::*;
#(
  parameter int WORDSIZE   = 16,
  parameter int BASE       = GPUBUF_BASE,
  parameter int LENGTH     = GPUBUF_SIZE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                mem_req,
  output logic [WORDSIZE-1:0] mem_addr,
  input  logic [WORDSIZE-1:0] mem_rdata,
  input  logic                mem_ready,
  output logic [WORDSIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int IDX_W = $clog2(LENGTH + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [WORDSIZE-1:0] addr_q;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                capture;
  logic                push;
  logic                pop;
  logic                last_pop;

  // A request is only raised while there is guaranteed room for its data,
  // so a granted word can always be pushed.
  assign mem_req   = (state == ST_FETCH) & ~fifo_full;
  assign mem_addr  = addr_q;
  assign capture   = mem_req & mem_ready;
  assign push      = capture & ~abort;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  // The run finishes as the final buffered word is handed downstream.
  assign last_pop  = (state == ST_DRAIN) & pop & (fifo_count == CNT_W'(1));

  stream_fifo #(
    .WIDTH (WORDSIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .wdata (mem_rdata),
    .rdata (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Run control: state, word index, held request address and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      idx    <= '0;
      addr_q <= WORDSIZE'(BASE);
    end else begin
      done <= 1'b0;
      if (abort) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        idx    <= '0;
        addr_q <= WORDSIZE'(BASE);
      end else begin
        case (state)
          ST_IDLE: begin
            idx    <= '0;
            addr_q <= WORDSIZE'(BASE);
            if (start) begin
              state <= ST_FETCH;
              busy  <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (capture) begin
              idx    <= idx + 1'b1;
              addr_q <= addr_q + 1'b1;
              if (idx == IDX_W'(LENGTH - 1)) state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (last_pop || fifo_empty) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmu_stream_reader.sv
// Bench for mmu_stream_reader: an MMU responder model with programmable
// latency, a stream scoreboard, a table of run scenarios and hand-written
// abort / reset / address-wrap sequences.
module tb_mmu_stream_reader;

  localparam int WS    = 16;
  localparam int BASE  = 3072;
  localparam int LEN   = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, mem_req, out_valid;
  logic          mem_ready = 1'b0;
  logic          out_ready = 1'b1;
  logic [WS-1:0] mem_addr, out_data;
  logic [WS-1:0] mem_rdata = '0;

  logic          w_start = 1'b0;
  logic          w_abort = 1'b0;
  logic          w_busy, w_done, w_req, w_valid;
  logic          w_ready = 1'b0;
  logic          w_out_ready = 1'b1;
  logic [WS-1:0] w_addr, w_data;
  logic [WS-1:0] w_rdata = '0;

  always #5 clk = ~clk;

  mmu_stream_reader #(.WORDSIZE(WS), .BASE(BASE), .LENGTH(LEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready));

  mmu_stream_reader #(.WORDSIZE(WS), .BASE(16'hFFFE), .LENGTH(4), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort), .busy(w_busy), .done(w_done),
    .mem_req(w_req), .mem_addr(w_addr), .mem_rdata(w_rdata), .mem_ready(w_ready),
    .out_data(w_data), .out_valid(w_valid), .out_ready(w_out_ready));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MMU responder: answers a held request after 'gap' idle cycles with rdata=addr
  int gap = 0;
  int wait_cnt = 0;
  bit abort_arm = 1'b0;

  always @(negedge clk) begin
    abort = 1'b0;
    if (mem_req !== 1'b1) begin
      mem_ready = 1'b0;
      mem_rdata = 16'hDEAD;
      wait_cnt  = 0;
    end else if (wait_cnt >= gap) begin
      mem_ready = 1'b1;
      mem_rdata = mem_addr;
      wait_cnt  = 0;
      if (abort_arm && mem_addr == 16'(BASE + 5)) abort = 1'b1;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 16'hDEAD;
      wait_cnt++;
    end
  end

  // Stream monitor / scoreboard
  logic [WS-1:0] sb[$];
  int  pops = 0, caps = 0, dones = 0;
  bit  hs_last = 1'b0, hs_d1 = 1'b0;

  always @(negedge clk) begin
    logic [WS-1:0] e;
    #1;
    hs_d1   = hs_last;
    hs_last = (out_valid === 1'b1) && (out_ready === 1'b1);
    if (hs_last) begin
      pops++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        e = sb.pop_front();
        check("stream_word", 32'(out_data), 32'(e));
      end
    end
    if (mem_req === 1'b1 && mem_ready === 1'b1) caps++;
    if (done === 1'b1) dones++;
  end

  typedef struct {
    int    gap;
    int    stall_at;
    int    stall_len;
    bit    mid_start;
    int    exp_words;
    int    exp_dones;
    string tag;
  } run_t;

  task automatic run_one(input run_t r);
    int p0 = pops, c0 = caps, d0 = dones;
    int first = -1, last = -1, st_cnt = 0;
    bit stalling = 0, stalled = 0, fin = 0;
    logic [WS-1:0] hold = '0, exp_addr;
    gap = r.gap;
    @(negedge clk);
    out_ready = 1'b1;
    start = 1'b1;
    for (int i = 0; i < LEN; i++) sb.push_back(16'(BASE + i));
    exp_addr = 16'(BASE);
    @(negedge clk);
    start = 1'b0;
    #2;
    check({r.tag, ".start_busy"}, 32'(busy), 32'd1);
    check({r.tag, ".start_req"}, 32'(mem_req), 32'd1);
    check({r.tag, ".start_addr"}, 32'(mem_addr), 32'(BASE));
    if (mem_req && mem_ready) exp_addr++;
    for (int k = 1; k < 400 && !fin; k++) begin
      @(negedge clk);
      start = r.mid_start && (k == 6);
      if (r.stall_at >= 0 && !stalled && !stalling && (pops - p0) >= r.stall_at) begin
        stalling = 1; out_ready = 1'b0; st_cnt = 0;
      end else if (stalling) begin
        st_cnt++;
        if (st_cnt > r.stall_len) begin stalling = 0; stalled = 1; out_ready = 1'b1; end
      end
      #2;
      if (stalling && st_cnt == 10) hold = mem_addr;
      if (stalling && st_cnt == r.stall_len) begin
        check({r.tag, ".stall_req"}, 32'(mem_req), 32'd0);
        check({r.tag, ".stall_addr"}, 32'(mem_addr), 32'(hold));
        check({r.tag, ".stall_fill"}, (caps - c0) - (pops - p0), DEPTH);
        check({r.tag, ".stall_valid"}, 32'(out_valid), 32'd1);
      end
      if (hs_last) begin
        if (first < 0) first = k;
        last = k;
      end
      if (busy === 1'b1) begin
        check({r.tag, ".addr"}, 32'(mem_addr), 32'(exp_addr));
        if (mem_req && mem_ready) exp_addr++;
      end else begin
        check({r.tag, ".done_with_busy_fall"}, 32'(done), 32'd1);
        check({r.tag, ".done_after_last_pop"}, 32'(hs_d1), 32'd1);
        fin = 1;
      end
    end
    if (!fin) begin
      n_cmp++; n_fail++;
      $display("FAIL %s.timeout: got busy expected idle", r.tag);
    end
    check({r.tag, ".word_count"}, pops - p0, r.exp_words);
    check({r.tag, ".done_count"}, dones - d0, r.exp_dones);
    check({r.tag, ".sb_empty"}, sb.size(), 0);
    if (r.stall_at < 0 && r.gap == 0)
      check({r.tag, ".throughput_span"}, last - first, LEN - 1);
    @(negedge clk);
    #2;
    check({r.tag, ".idle_addr"}, 32'(mem_addr), 32'(BASE));
    check({r.tag, ".idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    run_t runs[4];
    int p0, d0;
    bit hit;
    logic [WS-1:0] wexp[4];
    int wa, wd, wdone;

    runs[0] = '{0, -1, 0,  1'b0, LEN, 1, "basic"};
    runs[1] = '{0,  2, 20, 1'b0, LEN, 1, "backpressure"};
    runs[2] = '{2, -1, 0,  1'b1, LEN, 1, "slow_restart"};
    runs[3] = '{1,  3, 20, 1'b0, LEN, 1, "slow_backpressure"};

    // Reset values
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'(BASE));
    check("rst_wrap_addr", 32'(w_addr), 32'hFFFE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_one(runs[i]);

    // Abort on word 5 together with its mem_ready
    gap = 1;
    p0 = pops; d0 = dones; hit = 0;
    @(negedge clk);
    out_ready = 1'b1; start = 1'b1; abort_arm = 1'b1;
    for (int i = 0; i < 5; i++) sb.push_back(16'(BASE + i));
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      #2;
      if (abort === 1'b1) hit = 1;
    end
    check("abort_seen", 32'(hit), 32'd1);
    @(negedge clk);
    abort_arm = 1'b0;
    #2;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_req", 32'(mem_req), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'(BASE));
    repeat (5) @(negedge clk);
    #2;
    check("abort_no_done", dones - d0, 0);
    check("abort_words", pops - p0, 5);
    check("abort_sb_empty", sb.size(), 0);
    run_one('{0, -1, 0, 1'b0, LEN, 1, "refetch"});

    // Asynchronous reset mid-run
    gap = 0;
    p0 = pops;
    @(negedge clk);
    out_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < LEN; i++) sb.push_back(16'(BASE + i));
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && (pops - p0) < 3; k++) @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #3;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'(BASE));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #2;
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);

    // Address wrap at the top of the address space
    wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;
    wa = 0; wd = 0; wdone = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      w_start = (k == 0);
      w_ready = w_req;
      w_rdata = w_addr;
      #2;
      if (w_req && w_ready) begin
        if (wa < 4) check("wrap_addr", 32'(w_addr), 32'(wexp[wa]));
        wa++;
      end
      if (w_valid) begin
        if (wd < 4) check("wrap_data", 32'(w_data), 32'(wexp[wd]));
        wd++;
      end
      if (w_done) wdone++;
    end
    check("wrap_fetches", wa, 4);
    check("wrap_words", wd, 4);
    check("wrap_done", wdone, 1);
    check("wrap_idle", 32'(w_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
